// File: rtl/bolt_pool_move.sv
// Pool of NUM_BOLTS vertical projectiles for one shooter.
// Fires on the shootCmd rising edge with a frame cooldown, moves bolts each frame, and retires them off-screen or on hit.
module bolt_pool_move #(
    parameter int NUM_BOLTS       = 4,
    parameter int DIRECTION       = -1,
    parameter int SPEED_Y         = 10,
    parameter int OFFSET_X        = 0,
    parameter int OFFSET_Y        = 0,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int Y_MIN           = 0,
    parameter int Y_MAX           = 479,
    parameter int FRAC_BITS       = 6
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      startOfFrame,
    input  logic                      shootCmd,
    input  logic [10:0]               init_x,
    input  logic [10:0]               init_y,
    input  logic [NUM_BOLTS-1:0]      hitMask,
    output logic [11*NUM_BOLTS-1:0]   topLeftX,
    output logic [11*NUM_BOLTS-1:0]   topLeftY,
    output logic [NUM_BOLTS-1:0]      activeMask,
    output logic                      fireAccepted,
    output logic                      fireDropped
);

    localparam logic [10:0] HIDDEN = 11'd2028;
    localparam int CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam int SEL_W = (NUM_BOLTS > 1) ? $clog2(NUM_BOLTS) : 1;
    localparam logic signed [31:0] STEP = 32'(DIRECTION * SPEED_Y * (1 << FRAC_BITS));

    function automatic logic signed [31:0] int_part(input logic signed [31:0] fp);
        return fp >>> FRAC_BITS;
    endfunction

    function automatic logic [10:0] to_coord(input logic signed [31:0] fp);
        return 11'(int_part(fp));
    endfunction

    function automatic logic signed [31:0] to_fp(input logic [10:0] v, input int off);
        logic signed [31:0] t;
        t = $signed({21'd0, v}) + 32'(off);
        return t <<< FRAC_BITS;
    endfunction

    function automatic logic off_screen(input logic signed [31:0] fp);
        return (int_part(fp) < 32'(Y_MIN)) || (int_part(fp) > 32'(Y_MAX));
    endfunction

    function automatic logic [CD_W-1:0] cd_dec(input logic [CD_W-1:0] c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

    logic                     prvSht;
    logic                     armed;
    logic [CD_W-1:0]          cooldown;
    logic signed [31:0]       x_fp [NUM_BOLTS];
    logic signed [31:0]       y_fp [NUM_BOLTS];

    logic                     fire;
    logic                     accept;
    logic [SEL_W-1:0]         sel;
    logic [NUM_BOLTS-1:0]     act_nx;
    logic [CD_W-1:0]          cd_nx;
    logic signed [31:0]       x_nx [NUM_BOLTS];
    logic signed [31:0]       y_nx [NUM_BOLTS];
    logic signed [31:0]       y_mv [NUM_BOLTS];

    // armed blocks a level still held high across reset release from looking like an edge
    assign fire   = shootCmd & ~prvSht & armed;
    assign accept = fire && (cooldown == '0) && (activeMask != '1);

    always_comb begin
        sel    = '0;
        act_nx = activeMask;
        cd_nx  = cooldown;
        for (int i = NUM_BOLTS - 1; i >= 0; i--) begin
            if (!activeMask[i]) sel = SEL_W'(i);
        end
        if (startOfFrame) cd_nx = cd_dec(cooldown);
        if (accept) cd_nx = CD_W'(COOLDOWN_FRAMES);
        for (int i = 0; i < NUM_BOLTS; i++) begin
            x_nx[i] = x_fp[i];
            y_nx[i] = y_fp[i];
            y_mv[i] = y_fp[i] + STEP;
            if (accept && sel == SEL_W'(i)) begin
                act_nx[i] = 1'b1;
                x_nx[i]   = to_fp(init_x, OFFSET_X);
                y_nx[i]   = to_fp(init_y, OFFSET_Y);
            end else if (activeMask[i]) begin
                if (hitMask[i]) begin
                    act_nx[i] = 1'b0;
                end else if (startOfFrame) begin
                    y_nx[i] = y_mv[i];
                    if (off_screen(y_mv[i])) act_nx[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            activeMask   <= '0;
            cooldown     <= '0;
            prvSht       <= 1'b0;
            armed        <= 1'b0;
            fireAccepted <= 1'b0;
            fireDropped  <= 1'b0;
            topLeftX     <= {NUM_BOLTS{HIDDEN}};
            topLeftY     <= {NUM_BOLTS{HIDDEN}};
        end else begin
            activeMask   <= act_nx;
            cooldown     <= cd_nx;
            prvSht       <= shootCmd;
            armed        <= armed | ~shootCmd;
            fireAccepted <= accept;
            fireDropped  <= fire & ~accept;
            for (int i = 0; i < NUM_BOLTS; i++) begin
                topLeftX[11*i +: 11] <= activeMask[i] ? to_coord(x_fp[i]) : HIDDEN;
                topLeftY[11*i +: 11] <= activeMask[i] ? to_coord(y_fp[i]) : HIDDEN;
            end
        end
    end

    // Positions are only observed while their slot is active, so they carry no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BOLTS; i++) begin
            x_fp[i] <= x_nx[i];
            y_fp[i] <= y_nx[i];
        end
    end

endmodule
